// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encodings and counter width helper for the keypad front end
package button_pkg;

  localparam logic RELEASED = 1'b0;
  localparam logic HELD     = 1'b1;

  // Counter width for a terminal count of value-1, never narrower than one bit.
  function automatic int cnt_width(input int value);
    if (value <= 1) return 1;
    return $clog2(value);
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: synchroniser, debouncer, press/release FSM and auto-repeat
module key_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_edge,
  output logic key_release,
  output logic key_repeat
);

  localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RPT_W = cnt_width(REPEAT_DELAY);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             state_q, state_d;
  logic             edge_q, edge_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  always_comb begin
    sync1_d   = key_in;
    sync2_d   = sync1_q;
    db_cnt_d  = db_cnt_q;
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    edge_d    = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    if (sync2_q == state_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      state_d  = ~state_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    // A release on the same edge as a due repeat wins, so the repeat is dropped.
    if (state_q == RELEASED && state_d == HELD) begin
      edge_d    = 1'b1;
      rpt_cnt_d = '0;
    end else if (state_q == HELD && state_d == RELEASED) begin
      release_d = 1'b1;
      rpt_cnt_d = '0;
    end else if (state_q == HELD && REPEAT_EN != 0) begin
      if (rpt_cnt_q == RPT_LAST) begin
        repeat_d  = 1'b1;
        rpt_cnt_d = RPT_RELOAD;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end else begin
      rpt_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      rpt_cnt_q <= '0;
      state_q   <= RELEASED;
      edge_q    <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      state_q   <= state_d;
      edge_q    <= edge_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign key_level   = (state_q == HELD);
  assign key_edge    = edge_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;

endmodule

// File: rtl/button_array_monitor.sv
// rtl/button_array_monitor.sv - NUM_KEYS independent debounced key channels
module button_array_monitor
  import button_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] keyLevel,
  output logic [NUM_KEYS-1:0] keyEdge,
  output logic [NUM_KEYS-1:0] keyRelease,
  output logic [NUM_KEYS-1:0] keyRepeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .key_in     (key[i]),
      .key_level  (keyLevel[i]),
      .key_edge   (keyEdge[i]),
      .key_release(keyRelease[i]),
      .key_repeat (keyRepeat[i])
    );
  end

endmodule

// File: tb/tb_button_array_monitor.sv
// tb/tb_button_array_monitor.sv - directed table and sequence checks for button_array_monitor
module tb_button_array_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key   = 4'b0;
  logic [3:0] key_b = 4'b0;
  logic [3:0] keyLevel, keyEdge, keyRelease, keyRepeat;
  logic [3:0] nr_level, nr_edge, nr_release, nr_repeat;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  button_array_monitor #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_dut (
    .clock(clock), .reset(reset), .key(key),
    .keyLevel(keyLevel), .keyEdge(keyEdge), .keyRelease(keyRelease), .keyRepeat(keyRepeat)
  );

  button_array_monitor #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_nr (
    .clock(clock), .reset(reset), .key(key_b),
    .keyLevel(nr_level), .keyEdge(nr_edge), .keyRelease(nr_release), .keyRepeat(nr_repeat)
  );

  typedef struct {
    logic [3:0] key;
    logic [3:0] lvl;
    logic [3:0] edg;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  vec_t tbl [30];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int got;
    int n_edges;
    int n_rpts;
    logic exp_lvl, exp_rel, exp_rpt;

    // Segment A: glitch on key[1] alongside a clean press/release on key[0].
    tbl[0]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    // Segment B: all four keys pressed and released together.
    tbl[16] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[18] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[19] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[20] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[21] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
    tbl[22] = '{4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[23] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[24] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[25] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[26] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[27] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[28] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    tbl[29] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    step();
    step();
    chk("reset_outputs", {16'h0, keyLevel, keyEdge, keyRelease, keyRepeat}, 32'h0);
    reset = 1'b0;
    step();
    step();
    chk("idle_outputs", {16'h0, keyLevel, keyEdge, keyRelease, keyRepeat}, 32'h0);

    for (int i = 0; i < 30; i++) begin
      key = tbl[i].key;
      step();
      chk($sformatf("table vec %0d", i), {16'h0, keyLevel, keyEdge, keyRelease, keyRepeat},
          {16'h0, tbl[i].lvl, tbl[i].edg, tbl[i].rel, tbl[i].rpt});
      chk($sformatf("table norpt vec %0d", i), {16'h0, nr_level, nr_edge, nr_release, nr_repeat}, 32'h0);
    end

    // Auto-repeat on key[2]; the release lands on a cycle where a repeat would be due.
    key = 4'b0100;
    got = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (keyEdge[2] === 1'b1) begin
        got = n;
        break;
      end
    end
    chk("rpt press latency", got, 6);
    for (int k = 1; k <= 47; k++) begin
      if (k == 32) key = 4'b0000;
      step();
      exp_lvl = (k <= 36);
      exp_rel = (k == 37);
      exp_rpt = (k >= 10 && k <= 36 && ((k - 10) % 3) == 0);
      chk($sformatf("rpt k=%0d", k), {28'h0, keyLevel[2], keyEdge[2], keyRelease[2], keyRepeat[2]},
          {28'h0, exp_lvl, 1'b0, exp_rel, exp_rpt});
    end

    // Reset in the middle of repeating on key[3], key still held afterwards.
    key = 4'b1000;
    got = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (keyRepeat[3] === 1'b1) begin
        got = n;
        break;
      end
    end
    chk("rst first repeat", got, 16);
    #3;
    reset = 1'b1;
    #1;
    chk("rst async clear", {16'h0, keyLevel, keyEdge, keyRelease, keyRepeat}, 32'h0);
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("rst rearm e=%0d", e), {16'h0, keyLevel, keyEdge, keyRelease, keyRepeat},
          {16'h0, (e >= 6) ? 4'b1000 : 4'b0000, (e == 6) ? 4'b1000 : 4'b0000, 8'h00});
    end
    key = 4'b0000;

    // Repeat disabled build: long hold gives exactly one press pulse and no repeats.
    key_b = 4'b0001;
    n_edges = 0;
    n_rpts = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (nr_edge[0] === 1'b1) n_edges++;
      if (nr_repeat !== 4'b0000) n_rpts++;
    end
    chk("norpt edge count", n_edges, 1);
    chk("norpt repeat count", n_rpts, 0);
    chk("norpt level held", {31'h0, nr_level[0]}, 32'h1);
    key_b = 4'b0000;
    for (int n = 1; n <= 8; n++) step();
    chk("norpt level released", {28'h0, nr_level}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
